// File: rtl/div_result_display.sv
// div_result_display
//   Display stage that sits behind the 4-bit sequential restoring divider.
//   It counts the divider's fixed latency from the shared Go strobe, captures
//   Quotient/Remainder once they are final, converts each to two decimal
//   digits by repeated subtraction of ten, and drives four active-low
//   7-segment displays (quotient on HEX3:HEX2, remainder on HEX1:HEX0).
//   A zero divisor is reported as "Err" with DivZero set.
//
// Handshake: Go is a start strobe accepted only in IDLE or SHOW. Busy is high
//   from the cycle after an accepted Go until conversion ends; Done pulses
//   for exactly one cycle when the new result appears on the displays.
//
// Ports:
//   Clock      in   rising-edge clock
//   Resetn     in   synchronous active-low reset
//   Go         in   start strobe (same signal that starts the divider)
//   Divisor    in   W bits, sampled together with Go
//   Quotient   in   W bits, divider quotient
//   Remainder  in   W bits, divider remainder
//   HEX3..HEX0 out  7 bits each, active-low segments {g,f,e,d,c,b,a}
//   Busy       out  result being waited for or converted
//   Done       out  one-cycle pulse on first SHOW cycle
//   DivZero    out  displayed result came from a zero divisor
module div_result_display #(
    parameter int W           = 4,
    parameter int DIV_LATENCY = 5
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         Go,
    input  logic [W-1:0] Divisor,
    input  logic [W-1:0] Quotient,
    input  logic [W-1:0] Remainder,
    output logic [6:0]   HEX3,
    output logic [6:0]   HEX2,
    output logic [6:0]   HEX1,
    output logic [6:0]   HEX0,
    output logic         Busy,
    output logic         Done,
    output logic         DivZero
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_CAPTURE = 3'd2,
        S_CONV_Q  = 3'd3,
        S_CONV_R  = 3'd4,
        S_SHOW    = 3'd5
    } state_t;

    localparam int          CW        = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [W-1:0] TEN      = W'(10);
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_E     = 7'b0000110;
    localparam logic [6:0]  SEG_R     = 7'b0101111;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  wait_cnt;
    logic [W-1:0]   div_r;
    logic [W-1:0]   q_work;
    logic [W-1:0]   r_work;
    logic [2:0]     q_tens;
    logic [2:0]     r_tens;
    logic [3:0]     q_ones;

    logic           show_load;
    logic [6:0]     hex3_nxt;
    logic [6:0]     hex2_nxt;
    logic [6:0]     hex1_nxt;
    logic [6:0]     hex0_nxt;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Leading zero suppression for the tens position.
    function automatic logic [6:0] seg7_tens(input logic [2:0] t);
        return (t == 3'd0) ? SEG_BLANK : seg7({1'b0, t});
    endfunction

    // Next-state logic and display values for the SHOW entry edge.
    always_comb begin
        state_nxt = state;
        hex3_nxt  = SEG_BLANK;
        hex2_nxt  = SEG_BLANK;
        hex1_nxt  = SEG_BLANK;
        hex0_nxt  = SEG_BLANK;

        case (state)
            S_IDLE, S_SHOW: if (Go) state_nxt = S_WAIT;
            S_WAIT:         if (wait_cnt == '0) state_nxt = S_CAPTURE;
            S_CAPTURE:      state_nxt = (div_r == '0) ? S_SHOW : S_CONV_Q;
            S_CONV_Q:       if (q_work < TEN) state_nxt = S_CONV_R;
            S_CONV_R:       if (r_work < TEN) state_nxt = S_SHOW;
            default:        state_nxt = S_IDLE;
        endcase

        show_load = (state_nxt == S_SHOW) && (state != S_SHOW);

        if (state == S_CAPTURE) begin
            hex3_nxt = SEG_E;
            hex2_nxt = SEG_R;
            hex1_nxt = SEG_R;
            hex0_nxt = SEG_BLANK;
        end else begin
            // Leaving CONV_R: r_work already holds the remainder ones digit,
            // so it feeds HEX0 directly on the same edge.
            hex3_nxt = seg7_tens(q_tens);
            hex2_nxt = seg7(q_ones);
            hex1_nxt = seg7_tens(r_tens);
            hex0_nxt = seg7(r_work[3:0]);
        end
    end

    // State register with registered status outputs.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_nxt;
            Busy  <= state_nxt inside {S_WAIT, S_CAPTURE, S_CONV_Q, S_CONV_R};
            Done  <= show_load;
        end
    end

    // Working registers and display registers.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            wait_cnt <= '0;
            div_r    <= '0;
            q_work   <= '0;
            r_work   <= '0;
            q_tens   <= 3'd0;
            r_tens   <= 3'd0;
            q_ones   <= 4'd0;
            HEX3     <= SEG_BLANK;
            HEX2     <= SEG_BLANK;
            HEX1     <= SEG_BLANK;
            HEX0     <= SEG_BLANK;
            DivZero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_SHOW: begin
                    if (Go) begin
                        div_r    <= Divisor;
                        wait_cnt <= CW'(DIV_LATENCY - 1);
                    end
                end
                S_WAIT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - CW'(1);
                end
                S_CAPTURE: begin
                    q_work <= Quotient;
                    r_work <= Remainder;
                    q_tens <= 3'd0;
                    r_tens <= 3'd0;
                end
                S_CONV_Q: begin
                    if (q_work >= TEN) begin
                        q_work <= q_work - TEN;
                        q_tens <= q_tens + 3'd1;
                    end else begin
                        q_ones <= q_work[3:0];
                    end
                end
                S_CONV_R: begin
                    if (r_work >= TEN) begin
                        r_work <= r_work - TEN;
                        r_tens <= r_tens + 3'd1;
                    end
                end
                default: ;
            endcase

            if (show_load) begin
                HEX3    <= hex3_nxt;
                HEX2    <= hex2_nxt;
                HEX1    <= hex1_nxt;
                HEX0    <= hex0_nxt;
                DivZero <= (state == S_CAPTURE);
            end
        end
    end

endmodule

// File: tb/tb_div_result_display.sv
module tb_div_result_display;

    localparam int TW = 6;
    localparam int DL = 5;
    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [28:0] DISP_BLANK = {1'b0, BLK, BLK, BLK, BLK};

    logic          Clock;
    logic          Resetn;
    logic          Go;
    logic [TW-1:0] Divisor;
    logic [TW-1:0] Quotient;
    logic [TW-1:0] Remainder;
    logic [6:0]    HEX3, HEX2, HEX1, HEX0;
    logic          Busy, Done, DivZero;

    div_result_display #(.W(TW), .DIV_LATENCY(DL)) dut (
        .Clock(Clock), .Resetn(Resetn), .Go(Go), .Divisor(Divisor),
        .Quotient(Quotient), .Remainder(Remainder),
        .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0),
        .Busy(Busy), .Done(Done), .DivZero(DivZero)
    );

    // ---------------- clock ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    function automatic logic [6:0] tens_seg(input int t);
        return (t == 0) ? BLK : seg_tab[t];
    endfunction

    // {DivZero, HEX3, HEX2, HEX1, HEX0} expected for a result
    function automatic logic [28:0] model_disp(input int dv, input int q, input int r);
        if (dv == 0) return {1'b1, 7'b0000110, 7'b0101111, 7'b0101111, BLK};
        return {1'b0, tens_seg(q / 10), seg_tab[q % 10], tens_seg(r / 10), seg_tab[r % 10]};
    endfunction

    function automatic logic [28:0] disp();
        return {DivZero, HEX3, HEX2, HEX1, HEX0};
    endfunction

    // ---------------- scoreboard ----------------
    logic [28:0] exp_q[$];
    int          lat_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [28:0] last_disp = DISP_BLANK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expected result whenever Done is presented, and
    // checks how many cycles Busy was high before it.
    int   run_len = 0;
    logic prev_done = 1'b0;
    always @(negedge Clock) begin
        if (Done) begin
            if (prev_done) check("done_width", 32'd2, 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("display", {3'b0, disp()}, {3'b0, exp_q.pop_front()});
                check("busy_len", run_len, lat_q.pop_front());
            end
            run_len = 0;
        end else if (Busy) begin
            run_len++;
        end else begin
            run_len = 0;
        end
        prev_done = Done;
    end

    // ---------------- driver ----------------
    // Called at posedge+1. Quotient/Remainder carry the true values only in
    // the cycle before the capture edge, so a mistimed capture is visible.
    task automatic run_txn(input int dv, input int q, input int r,
                           input bit extra, input bit abort);
        logic [28:0] e;
        int          lat;
        e   = model_disp(dv, q, r);
        lat = DL + 1 + ((dv == 0) ? 0 : (q / 10 + r / 10 + 2));
        exp_q.push_back(e);
        lat_q.push_back(lat);

        Go = 1'b1; Divisor = TW'(dv); Quotient = ~TW'(q); Remainder = ~TW'(r);
        @(posedge Clock); #1;
        Go = 1'b0; Divisor = TW'($urandom);
        for (int i = 1; i <= DL; i++) begin
            @(posedge Clock); #1;
            Go = extra && (i == 2);
            if (extra && i == 2) Divisor = '0;
            if (i == 2) check("hold_during_wait", {3'b0, disp()}, {3'b0, last_disp});
            if (i == DL) begin
                Quotient = TW'(q); Remainder = TW'(r);
            end
        end
        @(posedge Clock); #1;
        Quotient = ~TW'(q); Remainder = ~TW'(r);
        Go = extra;

        if (abort) begin
            Go = 1'b0;
            @(posedge Clock); #1;
            Resetn = 1'b0;
            @(posedge Clock); #1;
            check("abort_busy", {31'b0, Busy}, 32'd0);
            check("abort_done", {31'b0, Done}, 32'd0);
            check("abort_divzero", {31'b0, DivZero}, 32'd0);
            check("abort_hex", {3'b0, disp()}, {3'b0, DISP_BLANK});
            Resetn = 1'b1;
            exp_q.delete();
            lat_q.delete();
            last_disp = DISP_BLANK;
            return;
        end

        @(posedge Clock); #1;
        Go = 1'b0;
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge Clock);
        #1;
        if (exp_q.size() != 0) begin
            check("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
            lat_q.delete();
        end
        repeat (3) @(posedge Clock);
        #1;
        check("hold_in_show", {3'b0, disp()}, {3'b0, e});
        last_disp = e;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dv, a, q, r;
        Resetn = 1'b0; Go = 1'b1; Divisor = '0; Quotient = '0; Remainder = '0;
        repeat (3) @(posedge Clock);
        #1;
        check("reset_hex", {3'b0, disp()}, {3'b0, DISP_BLANK});
        check("reset_busy", {31'b0, Busy}, 32'd0);
        check("reset_done", {31'b0, Done}, 32'd0);
        Resetn = 1'b1; Go = 1'b0;
        @(posedge Clock); #1;
        // Go was high on the last reset edge: reset must have won.
        check("reset_wins_busy", {31'b0, Busy}, 32'd0);

        run_txn(4, 3, 1, 1'b0, 1'b0);
        run_txn(1, 15, 0, 1'b0, 1'b0);
        run_txn(2, 21, 0, 1'b1, 1'b0);
        run_txn(0, 5, 9, 1'b0, 1'b0);
        run_txn(5, 63, 57, 1'b0, 1'b1);
        run_txn(1, 63, 57, 1'b0, 1'b0);

        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge Clock); #1;
            end
            dv = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 63));
            a  = $urandom_range(0, 63);
            if (dv != 0) begin
                q = a / dv;
                r = a % dv;
            end else begin
                q = $urandom_range(0, 63);
                r = $urandom_range(0, 63);
            end
            run_txn(dv, q, r, bit'($urandom_range(0, 1)) && (dv != 0), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_result_display.md
Name: div_result_display

Overview:
Downstream stage of the 4-bit sequential restoring divider. It tracks the divider's fixed latency from the shared Go pulse and captures Quotient/Remainder. It converts each value to two decimal digits with an iterative subtract-by-ten FSM and drives four active-low 7-segment displays: quotient on HEX3:HEX2, remainder on HEX1:HEX0. A divide-by-zero is flagged and displayed as "Err".

Parameters:
W, 4, operand/result width; legal 4..6 (max value 63, two decimal digits).
DIV_LATENCY, 5, clock edges from the Go-sampling edge until divider outputs are final.

Ports:
Clock  in  1  system clock, rising edge.
Resetn  in  1  synchronous reset, active-low.
Go  in  1  start strobe, the same signal that drives the divider.
Divisor  in  W  divisor presented to the divider, sampled with Go.
Quotient  in  W  divider quotient output.
Remainder  in  W  divider remainder output.
HEX3  out  7  quotient tens digit, active-low segments {g,f,e,d,c,b,a}.
HEX2  out  7  quotient ones digit.
HEX1  out  7  remainder tens digit.
HEX0  out  7  remainder ones digit.
Busy  out  1  high in WAIT, CAPTURE, CONV_Q, CONV_R.
Done  out  1  one-cycle pulse on the first cycle of SHOW.
DivZero  out  1  high while the displayed result came from Divisor==0.

Behaviour:
- Reset (Resetn=0 at an edge), from any state including mid-conversion:
  - state IDLE; all HEX outputs 7'b1111111 (blank); Busy=0, Done=0, DivZero=0; all working registers 0.
- States: IDLE, WAIT, CAPTURE, CONV_Q, CONV_R, SHOW.
- IDLE/SHOW with Go=1 at an edge:
  - go to WAIT; latch Divisor into div_r; load wait counter with DIV_LATENCY-1.
  - HEX outputs and DivZero keep their previous values until the next SHOW entry.
- Go is ignored in WAIT, CAPTURE, CONV_Q and CONV_R.
- WAIT: counter decrements each edge. When counter==0 at an edge, go to CAPTURE.
- CAPTURE (one cycle):
  - latch Quotient into q_work and Remainder into r_work; clear tens counters.
  - If div_r==0, next state is SHOW with DivZero=1; otherwise CONV_Q.
  - Net effect: Quotient/Remainder are sampled DIV_LATENCY+1 edges after the Go edge.
- CONV_Q, one step per cycle:
  - If q_work>=10: q_work-=10, q_tens+=1, stay.
  - Else: q_ones=q_work, go to CONV_R.
- CONV_R: identical step on r_work/r_tens/r_ones; on exit go to SHOW.
- Conversion takes floor(Q/10)+floor(R/10)+2 cycles. Tens counters are 3 bits wide (max 6).
- Display update: HEX registers update on the edge entering SHOW, and Done is high for exactly that first SHOW cycle.
  - Normal result: tens digit is blanked when it is 0, so a value of 0 shows as blank/'0'.
  - DivZero result: HEX3='E' (0000110), HEX2='r' (0101111), HEX1='r', HEX0 blank.
- SHOW: holds its outputs indefinitely until Go or reset.
- Digit encodings (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Go and Resetn=0 at the same edge: reset wins.
- Busy is registered and follows the state it describes (high from the cycle after the Go edge through the last CONV_R cycle).

Test Plan:
- Reset, then Go=1 with Divisor=4 for one cycle; drive Quotient=3, Remainder=1 by the capture edge.
  -> Busy high for 5+1+2 cycles, then Done pulses once.
  -> HEX3=1111111, HEX2=0110000, HEX1=1111111, HEX0=1111001, DivZero=0.
- Divisor=1, Quotient=15, Remainder=0.
  -> CONV_Q takes 2 cycles.
  -> HEX3=1111001, HEX2=0010010, HEX1=1111111, HEX0=1000000.
- Divisor=0 with Go.
  -> no CONV states; SHOW after CAPTURE; DivZero=1.
  -> HEX3=0000110, HEX2=HEX1=0101111, HEX0=1111111.
- Extra Go pulses during WAIT and CONV_Q.
  -> ignored: Done pulses once at the original time; captured values come from the first Go.
- Resetn=0 during CONV_Q after a prior shown result.
  -> next cycle: IDLE, all HEX blank, Busy=0, DivZero=0. A subsequent Go completes normally.
- W=6, Quotient=63, Remainder=57.
  -> HEX3=0000010, HEX2=0110000, HEX1=0010010, HEX0=1111000; conversion takes 13 cycles.
